mpsoc_apb_gpio: RTL and testbench

//  APB4 slave GPIO peripheral. It sits directly downstream of the AHB-to-APB peripheral bridge and consumes its PSEL/PENABLE/PADDR/PWDATA/PSTRB beats.
//  It provides per-pin direction, push-pull/open-drain output, and synchronized input sampling.

---
 rtl/mpsoc_apb_gpio.sv | 131 +++++++++++++
 tb/tb_mpsoc_apb_gpio.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_apb_gpio.sv
// APB4 GPIO slave: per-pin direction, push-pull/open-drain output, synchronized inputs,
// and level/edge interrupt status with a masked, registered interrupt output.
module mpsoc_apb_gpio #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8,
  parameter int SYNC_DEPTH = 3
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic                  PSTRB,
  input  logic [PDATA_SIZE-1:0] PWDATA,
  output logic [PDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [PDATA_SIZE-1:0] gpio_i,
  output logic [PDATA_SIZE-1:0] gpio_o,
  output logic [PDATA_SIZE-1:0] gpio_oe,
  output logic                  irq_o
);

  localparam int SD = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_OUT    = 3'd2;
  localparam logic [2:0] A_IN     = 3'd3;
  localparam logic [2:0] A_TRTYPE = 3'd4;
  localparam logic [2:0] A_TRPOL  = 3'd5;
  localparam logic [2:0] A_TRSTAT = 3'd6;
  localparam logic [2:0] A_IRQEN  = 3'd7;

  logic [PDATA_SIZE-1:0]         r_mode;
  logic [PDATA_SIZE-1:0]         r_dir;
  logic [PDATA_SIZE-1:0]         r_out;
  logic [PDATA_SIZE-1:0]         r_trtype;
  logic [PDATA_SIZE-1:0]         r_trpol;
  logic [PDATA_SIZE-1:0]         r_trstat;
  logic [PDATA_SIZE-1:0]         r_irqen;
  logic [PDATA_SIZE-1:0]         r_prev;
  logic                          r_irq;
  logic [SD-1:0][PDATA_SIZE-1:0] r_sync;

  logic                  w_legal;
  logic [2:0]            w_addr;
  logic                  w_commit;
  logic [PDATA_SIZE-1:0] w_in;
  logic [PDATA_SIZE-1:0] w_trig;
  logic [PDATA_SIZE-1:0] w_clr;

  assign w_legal  = (PADDR[PADDR_SIZE-1:3] == '0);
  assign w_addr   = PADDR[2:0];
  assign PREADY   = 1'b1;
  assign w_commit = PSEL & PENABLE & PWRITE & PSTRB & PREADY & w_legal;
  assign PSLVERR  = PSEL & PENABLE & ~w_legal;
  assign w_in     = r_sync[SD-1];
  assign w_clr    = (w_commit && (w_addr == A_TRSTAT)) ? PWDATA : '0;
  assign irq_o    = r_irq;

  // Open-drain pins only ever pull low, so they release the pad whenever OUT is 1.
  assign gpio_oe = r_dir & ~(r_mode & r_out);
  assign gpio_o  = r_out & ~r_mode;

  for (genvar gi = 0; gi < PDATA_SIZE; gi++) begin : g_trig
    assign w_trig[gi] = r_trtype[gi]
      ? ((w_in[gi] & ~r_prev[gi] & r_trpol[gi]) | (~w_in[gi] & r_prev[gi] & ~r_trpol[gi]))
      : ~(w_in[gi] ^ r_trpol[gi]);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SD-2:0], gpio_i};
      r_prev <= w_in;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_mode   <= '0;
      r_dir    <= '0;
      r_out    <= '0;
      r_trtype <= '0;
      r_trpol  <= '0;
      r_irqen  <= '0;
    end else if (w_commit) begin
      case (w_addr)
        A_MODE:   r_mode   <= PWDATA;
        A_DIR:    r_dir    <= PWDATA;
        A_OUT:    r_out    <= PWDATA;
        A_TRTYPE: r_trtype <= PWDATA;
        A_TRPOL:  r_trpol  <= PWDATA;
        A_IRQEN:  r_irqen  <= PWDATA;
        default:  ;
      endcase
    end
  end

  // A fresh trigger is OR-ed in after the clear, so set wins over W1C.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_trstat <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_trstat <= (r_trstat & ~w_clr) | w_trig;
      r_irq    <= |(r_trstat & r_irqen);
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && w_legal) begin
      case (w_addr)
        A_MODE:   PRDATA = r_mode;
        A_DIR:    PRDATA = r_dir;
        A_OUT:    PRDATA = r_out;
        A_IN:     PRDATA = w_in;
        A_TRTYPE: PRDATA = r_trtype;
        A_TRPOL:  PRDATA = r_trpol;
        A_TRSTAT: PRDATA = r_trstat;
        default:  PRDATA = r_irqen;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_apb_gpio.sv
// Randomized bench for mpsoc_apb_gpio: a time-indexed behavioural model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_mpsoc_apb_gpio;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int SD = 3;
  localparam int N  = 4096;

  logic          PCLK    = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic [AW-1:0] PADDR   = '0;
  logic          PWRITE  = 1'b0;
  logic          PSTRB   = 1'b0;
  logic [DW-1:0] PWDATA  = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [DW-1:0] gpio_i  = '0;
  logic [DW-1:0] gpio_o;
  logic [DW-1:0] gpio_oe;
  logic          irq_o;

  int n_checks = 0;
  int n_errors = 0;

  mpsoc_apb_gpio #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .SYNC_DEPTH(SD)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // samp[k] is the pad value captured at edge k after reset; IN after edge n is the
  // sample taken SD-1 edges earlier, and prev is IN one edge before that.
  logic [DW-1:0] samp [N];
  logic [DW-1:0] m_reg [8];
  logic [DW-1:0] m_trstat;
  logic          m_irq;
  int            m_cyc;

  function automatic logic [DW-1:0] in_at(input int n);
    if (n - SD + 1 < 1) return '0;
    return samp[(n - SD + 1) % N];
  endfunction

  function automatic logic [DW-1:0] trig_of(input int n);
    logic [DW-1:0] cur, prv, t;
    cur = in_at(n);
    prv = in_at(n - 1);
    t = '0;
    for (int p = 0; p < DW; p++) begin
      if (m_reg[4][p]) t[p] = m_reg[5][p] ? (cur[p] && !prv[p]) : (!cur[p] && prv[p]);
      else             t[p] = (cur[p] == m_reg[5][p]);
    end
    return t;
  endfunction

  function automatic bit wr_ok();
    return PSEL && PENABLE && PWRITE && PSTRB && (PADDR[AW-1:3] == '0);
  endfunction

  function automatic logic [DW-1:0] clr_now();
    return (wr_ok() && PADDR[2:0] == 3'd6) ? PWDATA : '0;
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_cyc    <= 0;
      m_trstat <= '0;
      m_irq    <= 1'b0;
      for (int k = 0; k < 8; k++) m_reg[k] <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      samp[(m_cyc + 1) % N] <= gpio_i;
      if (wr_ok() && PADDR[2:0] != 3'd3 && PADDR[2:0] != 3'd6) m_reg[PADDR[2:0]] <= PWDATA;
      m_trstat <= (m_trstat & ~clr_now()) | trig_of(m_cyc);
      m_irq    <= |(m_trstat & m_reg[7]);
    end
  end

  function automatic logic [DW-1:0] exp_rd();
    if (!(PSEL && !PWRITE && PADDR[AW-1:3] == '0)) return '0;
    case (PADDR[2:0])
      3'd3:    return in_at(m_cyc);
      3'd6:    return m_trstat;
      default: return m_reg[PADDR[2:0]];
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_oe();
    logic [DW-1:0] v;
    v = '0;
    for (int p = 0; p < DW; p++) begin
      if (!m_reg[1][p])     v[p] = 1'b0;
      else if (m_reg[0][p]) v[p] = !m_reg[2][p];
      else                  v[p] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_o();
    logic [DW-1:0] v;
    for (int p = 0; p < DW; p++) v[p] = m_reg[0][p] ? 1'b0 : m_reg[2][p];
    return v;
  endfunction

  always @(negedge PCLK) begin
    check("prdata",  PRDATA,  exp_rd());
    check("pslverr", PSLVERR, PSEL && PENABLE && (PADDR[AW-1:3] != '0));
    check("pready",  PREADY,  1'b1);
    check("gpio_oe", gpio_oe, exp_oe());
    check("gpio_o",  gpio_o,  exp_o());
    check("irq_o",   irq_o,   m_irq);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s,
                           output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
    tick();
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 1'b0;
    $display("WR addr=0x%03h data=0x%02h strb=%0d slverr=%0d", a, d, s, err);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic e;
    apb_write(a, d, 1'b1, e);
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick();
    PENABLE = 1'b1;
    #1 d = PRDATA;
    err = PSLVERR;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("RD addr=0x%03h data=0x%02h slverr=%0d", a, d, err);
  endtask

  task automatic hold_read(input logic [AW-1:0] a);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
  endtask

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic          e;

    // Reset: every address reads 0 while held in reset.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
    for (int a = 0; a < 8; a++) begin
      PADDR = AW'(a);
      #1;
      check("reset_rd", PRDATA, 8'h00);
      check("reset_slverr", PSLVERR, 1'b0);
      $display("RD addr=0x%03h data=0x%02h in reset", PADDR, PRDATA);
    end
    check("reset_oe", gpio_oe, 8'h00);
    check("reset_irq", irq_o, 1'b0);
    idle();
    tick(); tick();
    PRESETn = 1'b1;
    tick();

    // Output drive modes.
    wr(10'd1, 8'hFF);
    wr(10'd2, 8'hA5);
    wr(10'd0, 8'h00);
    check("pp_oe", gpio_oe, 8'hFF);
    check("pp_o",  gpio_o,  8'hA5);
    wr(10'd0, 8'hFF);
    check("od_oe", gpio_oe, 8'h5A);
    check("od_o",  gpio_o,  8'h00);

    // Input synchronizer latency.
    gpio_i = 8'h3C;
    hold_read(10'd3);
    tick(); tick();
    check("in_edge2", PRDATA, 8'h00);
    tick();
    check("in_edge3", PRDATA, 8'h3C);
    idle();

    // Rising-edge trigger on pin 0.
    gpio_i = 8'h00;
    repeat (5) tick();
    wr(10'd4, 8'hFF);
    wr(10'd5, 8'h01);
    wr(10'd7, 8'h01);
    wr(10'd6, 8'hFF);
    gpio_i = 8'h01;
    hold_read(10'd6);
    tick(); tick(); tick();
    check("edge_stat_e3", PRDATA, 8'h00);
    check("edge_irq_e3", irq_o, 1'b0);
    tick();
    check("edge_stat_e4", PRDATA, 8'h01);
    check("model_stat_e4", m_trstat, 8'h01);
    check("edge_irq_e4", irq_o, 1'b0);
    tick();
    check("edge_irq_e5", irq_o, 1'b1);
    idle();
    wr(10'd6, 8'h01);
    hold_read(10'd6);
    #1;
    check("w1c_stat", PRDATA, 8'h00);
    check("w1c_irq_lag", irq_o, 1'b1);
    tick();
    check("w1c_irq", irq_o, 1'b0);
    gpio_i = 8'h00;
    repeat (6) tick();
    check("fall_noset", PRDATA, 8'h00);
    idle();

    // Level-high on pin 7 survives W1C; set wins over a simultaneous clear on pin 0.
    wr(10'd4, 8'h7F);
    wr(10'd5, 8'h81);
    gpio_i = 8'h80;
    repeat (5) tick();
    wr(10'd6, 8'h80);
    apb_read(10'd6, d, e);
    check("level_resets", d & 8'h80, 8'h80);
    check("model_level", m_trstat & 8'h80, 8'h80);
    gpio_i = 8'h81;
    tick(); tick();
    wr(10'd6, 8'h01);
    apb_read(10'd6, d, e);
    check("set_wins", d & 8'h01, 8'h01);

    // Illegal address and PSTRB=0.
    apb_write(10'h008, 8'hFF, 1'b1, e);
    check("illegal_wr_slverr", e, 1'b1);
    apb_read(10'h008, d, e);
    check("illegal_rd_data", d, 8'h00);
    check("illegal_rd_slverr", e, 1'b1);
    apb_read(10'd2, d, e);
    check("out_kept", d, 8'hA5);
    apb_write(10'd2, 8'h00, 1'b0, e);
    apb_read(10'd2, d, e);
    check("strb0_out", d, 8'hA5);
    apb_write(10'd3, 8'hFF, 1'b1, e);
    check("in_wr_noerr", e, 1'b0);

    // Randomized traffic with one asynchronous reset mid-transfer.
    for (int it = 0; it < 300; it++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 3) == 0) gpio_i = DW'($urandom);
      a = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a[AW-1:3] = 7'($urandom_range(1, 127));
      if (it == 150) begin
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 10'd1; PWDATA = 8'hFF; PSTRB = 1'b1;
        tick();
        PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check("midrst_oe", gpio_oe, 8'h00);
        check("midrst_irq", irq_o, 1'b0);
        $display("RST asserted mid-transfer");
        tick();
        idle();
        tick();
        PRESETn = 1'b1;
        tick();
      end else if ($urandom_range(0, 1) == 1) begin
        apb_write(a, DW'($urandom), logic'($urandom_range(0, 5) != 0), e);
      end else begin
        apb_read(a, d, e);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
